rd_arb: RTL and testbench
=========================

RD_ARB -- requirements
Module: rd_arb

Interface
REQ-001 Parameter: ADDR_W, 32, address width of the requester and master address ports.
REQ-002 Parameter: LEN_W, 10, width of the length field; the value is forwarded unchanged as burst length.
REQ-003 ACLK  in  1  single clock; all logic on the rising edge.
REQ-004 ARESETN  in  1  reset, synchronous and active-low.
REQ-005 CHn_REQ  in  1  request from requester n (n=0,1), level; held until CHn_DONE.
REQ-006 CHn_ADRS  in  ADDR_W  start address; stable while CHn_REQ is high.
REQ-007 CHn_LEN  in  LEN_W  burst length; stable while CHn_REQ is high.
REQ-008 CHn_GRANT  out  1  high from the issue cycle until the release cycle for requester n.
REQ-009 CHn_DONE  out  1  one-cycle completion pulse for requester n.
REQ-010 CHn_ERR  out  1  one-cycle pulse, coincident with CHn_DONE, when the request is rejected.
REQ-011 CHn_FIFO_WE  out  1  RD_FIFO_WE steered to requester n.
REQ-012 RD_START  out  1  one-cycle start pulse to the read master.
REQ-013 RD_ADRS  out  ADDR_W  registered address to the read master.
REQ-014 RD_LEN  out  LEN_W  registered length to the read master.
REQ-015 RD_READY  in  1  read master idle.
REQ-016 RD_DONE  in  1  read master completion pulse.
REQ-017 RD_FIFO_WE  in  1  read-data write enable from the read master.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, BUSY and RELEASE.
REQ-019 In IDLE with RD_READY=1 and at least one CHn_REQ, the FSM SHALL select the winner, latch its address and length into RD_ADRS/RD_LEN, and move to ISSUE on the next edge.
REQ-020 Default arbitration SHALL be round-robin: on simultaneous requests, the channel not served last wins; after reset, channel 0 is treated as the last served, so channel 1 wins the first tie.
REQ-021 ISSUE SHALL last exactly one cycle: RD_START=1 and the winner's CHn_GRANT rises; next state is BUSY.
REQ-022 BUSY SHALL hold until RD_DONE=1; then the next state is RELEASE.
REQ-023 RELEASE SHALL last one cycle: pulse CHn_DONE for the owner, drop CHn_GRANT, record the owner as last served, and return to IDLE.
REQ-024 Minimum spacing between two RD_START pulses SHALL be 4 cycles (IDLE, ISSUE, BUSY, RELEASE).
REQ-025 CHn_FIFO_WE SHALL be RD_FIFO_WE AND (owner==n) AND state in {ISSUE, BUSY}; this path is combinational, zero latency.
REQ-026 Any RD_FIFO_WE outside ISSUE/BUSY SHALL be dropped.
REQ-027 A selected request with CHn_LEN > 255 SHALL NOT be issued; the FSM SHALL go IDLE->RELEASE, pulsing CHn_DONE and CHn_ERR together with no RD_START.
REQ-028 A request that falls before the issue cycle SHALL be ignored; once issued, the transfer always completes.
REQ-029 An RD_DONE arriving in IDLE or ISSUE SHALL be ignored.
REQ-030 No channel SHALL be granted while RD_READY=0 in IDLE.

Reset
REQ-031 With ARESETN=0 at a rising edge: state IDLE, all outputs 0, RD_ADRS/RD_LEN 0, last served = channel 0.
REQ-032 Reset mid-transfer SHALL abort sequencing with no CHn_DONE; the read master is reset by the same ARESETN.

Configuration
REQ-033 Macro RD_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with channel 0 highest and the last-served record removed; when undefined, round-robin per REQ-020.

Structure
REQ-034 A shared package rd_arb_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, BUSY=2, RELEASE=3), the channel count 2 and the maximum length 255.
REQ-035 A sub-module rd_arb_rr SHALL implement the combinational 2-way winner select (inputs: requests, last served; output: winner).

Verification
REQ-036 Ch0 only, ADRS=0x1000, LEN=15, RD_READY=1 -> RD_START one cycle after the request, RD_ADRS=0x1000, RD_LEN=15, CH0_GRANT high until RD_DONE+1, CH0_DONE one cycle.
REQ-037 Ch0 and Ch1 request together for 4 transfers -> order 1,0,1,0 (RR build); with RD_ARB_FIXED_PRIO_EN -> 0,0,0,0 while CH0_REQ is held.
REQ-038 Ch1 LEN=300 -> CH1_DONE and CH1_ERR in the same cycle, no RD_START, next request served normally.
REQ-039 16 RD_FIFO_WE beats during a ch1 transfer -> exactly 16 CH1_FIFO_WE, 0 CH0_FIFO_WE; a stray RD_FIFO_WE in IDLE -> none.
REQ-040 RD_READY=0 with a pending request -> no RD_START; RD_READY=1 -> RD_START next cycle.
REQ-041 ARESETN low during BUSY -> all outputs 0 next edge, no DONE; after release, ch1 wins the first tie.

Source files
------------

// File: rtl/rd_arb_pkg.sv
// Shared definitions for the two-channel read arbiter: FSM encoding, channel
// count and the longest burst the read master accepts.
package rd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int NUM_CH  = 2;
   localparam int MAX_LEN = 255;

endpackage

// File: rtl/rd_arb_rr.sv
// Combinational 2-way winner select: a lone request wins outright, a tie goes
// to the channel that was not served last.
module rd_arb_rr
   import rd_arb_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  logic              last_i,
   output logic              win_o
);

   always_comb begin
      win_o = 1'b0;
      if (req_i == 2'b11) begin
         win_o = ~last_i;
      end else begin
         win_o = req_i[1];
      end
   end

endmodule

// File: rtl/rd_arb.sv
// Two-channel read arbiter in front of a single read master.
// Define RD_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module rd_arb
   import rd_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 10
)
(
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              CH0_REQ,
   input  logic [ADDR_W-1:0] CH0_ADRS,
   input  logic [LEN_W-1:0]  CH0_LEN,
   output logic              CH0_GRANT,
   output logic              CH0_DONE,
   output logic              CH0_ERR,
   output logic              CH0_FIFO_WE,
   input  logic              CH1_REQ,
   input  logic [ADDR_W-1:0] CH1_ADRS,
   input  logic [LEN_W-1:0]  CH1_LEN,
   output logic              CH1_GRANT,
   output logic              CH1_DONE,
   output logic              CH1_ERR,
   output logic              CH1_FIFO_WE,
   output logic              RD_START,
   output logic [ADDR_W-1:0] RD_ADRS,
   output logic [LEN_W-1:0]  RD_LEN,
   input  logic              RD_READY,
   input  logic              RD_DONE,
   input  logic              RD_FIFO_WE
);

   state_t              state_q;
   logic                owner_q;
   logic                start_q;
   logic [ADDR_W-1:0]   adrs_q;
   logic [LEN_W-1:0]    len_q;
   logic [NUM_CH-1:0]   grant_q;
   logic [NUM_CH-1:0]   done_q;
   logic [NUM_CH-1:0]   err_q;
   logic [NUM_CH-1:0]   req;
   logic [NUM_CH-1:0]   fifo_we;
   logic                last_sel;
   logic                win_d;
   logic [ADDR_W-1:0]   sel_adrs;
   logic [LEN_W-1:0]    sel_len;
   logic                sel_bad;
   logic                xfer_active;

   assign req = {CH1_REQ, CH0_REQ};

`ifdef RD_ARB_FIXED_PRIO_EN
   // Pretending channel 1 was always served last makes channel 0 win every tie.
   assign last_sel = 1'b1;
`else
   logic last_q;
   assign last_sel = last_q;
`endif

   rd_arb_rr u_rr (
      .req_i  (req),
      .last_i (last_sel),
      .win_o  (win_d)
   );

   assign sel_adrs = win_d ? CH1_ADRS : CH0_ADRS;
   assign sel_len  = win_d ? CH1_LEN  : CH0_LEN;
   assign sel_bad  = (sel_len > LEN_W'(MAX_LEN));

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         start_q <= 1'b0;
         adrs_q  <= '0;
         len_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
`ifndef RD_ARB_FIXED_PRIO_EN
         last_q  <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
         case (state_q)
            IDLE: begin
               if (RD_READY && (|req)) begin
                  owner_q <= win_d;
                  adrs_q  <= sel_adrs;
                  len_q   <= sel_len;
                  if (sel_bad) begin
                     // Oversized burst: complete with error, never reaches the master.
                     state_q        <= RELEASE;
                     done_q[win_d]  <= 1'b1;
                     err_q[win_d]   <= 1'b1;
                  end else begin
                     state_q        <= ISSUE;
                     start_q        <= 1'b1;
                     grant_q[win_d] <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state_q <= BUSY;
            end
            BUSY: begin
               if (RD_DONE) begin
                  state_q         <= RELEASE;
                  done_q[owner_q] <= 1'b1;
                  grant_q         <= '0;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
`ifndef RD_ARB_FIXED_PRIO_EN
               last_q  <= owner_q;
`endif
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign xfer_active = (state_q == ISSUE) || (state_q == BUSY);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign fifo_we[gi] = RD_FIFO_WE && xfer_active && (owner_q == 1'(gi));
   end

   assign CH0_GRANT   = grant_q[0];
   assign CH1_GRANT   = grant_q[1];
   assign CH0_DONE    = done_q[0];
   assign CH1_DONE    = done_q[1];
   assign CH0_ERR     = err_q[0];
   assign CH1_ERR     = err_q[1];
   assign CH0_FIFO_WE = fifo_we[0];
   assign CH1_FIFO_WE = fifo_we[1];
   assign RD_START    = start_q;
   assign RD_ADRS     = adrs_q;
   assign RD_LEN      = len_q;

endmodule

// File: tb/tb_rd_arb.sv
// Self-checking bench for rd_arb: a scoreboard of expected issues/rejections
// is filled as requests are raised and drained by a negedge monitor.
module tb_rd_arb;

   logic        ACLK;
   logic        ARESETN;
   logic        CH0_REQ, CH1_REQ;
   logic [31:0] CH0_ADRS, CH1_ADRS;
   logic [9:0]  CH0_LEN, CH1_LEN;
   logic        CH0_GRANT, CH0_DONE, CH0_ERR, CH0_FIFO_WE;
   logic        CH1_GRANT, CH1_DONE, CH1_ERR, CH1_FIFO_WE;
   logic        RD_START;
   logic [31:0] RD_ADRS;
   logic [9:0]  RD_LEN;
   logic        RD_READY, RD_DONE, RD_FIFO_WE;

   rd_arb dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .CH0_REQ     (CH0_REQ),
      .CH0_ADRS    (CH0_ADRS),
      .CH0_LEN     (CH0_LEN),
      .CH0_GRANT   (CH0_GRANT),
      .CH0_DONE    (CH0_DONE),
      .CH0_ERR     (CH0_ERR),
      .CH0_FIFO_WE (CH0_FIFO_WE),
      .CH1_REQ     (CH1_REQ),
      .CH1_ADRS    (CH1_ADRS),
      .CH1_LEN     (CH1_LEN),
      .CH1_GRANT   (CH1_GRANT),
      .CH1_DONE    (CH1_DONE),
      .CH1_ERR     (CH1_ERR),
      .CH1_FIFO_WE (CH1_FIFO_WE),
      .RD_START    (RD_START),
      .RD_ADRS     (RD_ADRS),
      .RD_LEN      (RD_LEN),
      .RD_READY    (RD_READY),
      .RD_DONE     (RD_DONE),
      .RD_FIFO_WE  (RD_FIFO_WE)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      int          ch;
      logic [31:0] adrs;
      logic [9:0]  len;
      bit          err;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor-owned counters
   int   cyc = 0;
   int   start_cnt = 0;
   int   done_cnt = 0;
   int   fifo_cnt0 = 0;
   int   fifo_cnt1 = 0;
   int   last_start = 0;
   bit   have_start = 0;
   exp_t e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int ch, input logic [31:0] adrs, input logic [9:0] len, input bit err);
      exp_t x;
      x.ch = ch; x.adrs = adrs; x.len = len; x.err = err;
      sb_q.push_back(x);
   endtask

   always @(negedge ACLK) begin
      cyc++;
      fifo_cnt0 += int'(CH0_FIFO_WE);
      fifo_cnt1 += int'(CH1_FIFO_WE);
      done_cnt  += int'(CH0_DONE) + int'(CH1_DONE);
      if (RD_START) begin
         start_cnt++;
         if (have_start) check("start_gap", 64'(cyc - last_start >= 4), 64'd1);
         have_start = 1;
         last_start = cyc;
         if (sb_q.size() == 0) begin
            check("start_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            $display("txn issue  ch%0d adrs 0x%08h len %0d", e.ch, RD_ADRS, RD_LEN);
            check("start_grant", 64'({CH1_GRANT, CH0_GRANT}), 64'(1) << e.ch);
            check("rd_adrs", 64'(RD_ADRS), 64'(e.adrs));
            check("rd_len", 64'(RD_LEN), 64'(e.len));
            check("start_on_reject", 64'(e.err), 64'd0);
         end
      end
      if (CH0_ERR || CH1_ERR) begin
         if (sb_q.size() == 0) begin
            check("err_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            $display("txn reject ch%0d len %0d", e.ch, e.len);
            check("err_ch", 64'({CH1_ERR, CH0_ERR}), 64'(1) << e.ch);
            check("err_with_done", 64'({CH1_DONE, CH0_DONE}), 64'({CH1_ERR, CH0_ERR}));
            check("err_expected", 64'(e.err), 64'd1);
            check("err_no_start", 64'(RD_START), 64'd0);
         end
      end
   end

   // Wait for RD_START; lat counts negedges from the call (2 = one cycle after an IDLE sample edge).
   task automatic wait_start(output int lat);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 50) begin
         @(negedge ACLK);
         n++;
         if (RD_START) seen = 1;
      end
      if (!seen) check("start_wait_timeout", 64'd0, 64'd1);
      lat = n;
   endtask

   // Act as the read master for one issued transfer; returns in the RELEASE cycle.
   task automatic serve(input int ch, input int beats, output int lat);
      wait_start(lat);
      @(posedge ACLK); #1;
      for (int b = 0; b < beats; b++) begin
         RD_FIFO_WE = 1'b1;
         @(posedge ACLK); #1;
      end
      RD_FIFO_WE = 1'b0;
      RD_DONE    = 1'b1;
      @(negedge ACLK);
      check("grant_busy", 64'({CH1_GRANT, CH0_GRANT}), 64'(1) << ch);
      @(posedge ACLK); #1;
      RD_DONE = 1'b0;
      @(negedge ACLK);
      check("done_pulse", 64'({CH1_DONE, CH0_DONE}), 64'(1) << ch);
      check("done_no_err", 64'({CH1_ERR, CH0_ERR}), 64'd0);
      check("grant_release", 64'({CH1_GRANT, CH0_GRANT}), 64'd0);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({CH1_GRANT, CH0_GRANT, CH1_DONE, CH0_DONE, CH1_ERR, CH0_ERR,
                  CH1_FIFO_WE, CH0_FIFO_WE, RD_START});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int s0, d0, f0, f1;
      int order[4];
      int order2[2];

`ifdef RD_ARB_FIXED_PRIO_EN
      order  = '{0, 0, 0, 0};
      order2 = '{0, 0};
`else
      order  = '{1, 0, 1, 0};
      order2 = '{1, 0};
`endif

      ARESETN = 1'b0;
      CH0_REQ = 1'b0; CH0_ADRS = '0; CH0_LEN = '0;
      CH1_REQ = 1'b0; CH1_ADRS = '0; CH1_LEN = '0;
      RD_READY = 1'b0; RD_DONE = 1'b0; RD_FIFO_WE = 1'b0;

      // Reset state
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_outputs", all_outs(), 64'd0);
      check("rst_rd_adrs", 64'(RD_ADRS), 64'd0);
      check("rst_rd_len", 64'(RD_LEN), 64'd0);
      @(posedge ACLK); #1;
      ARESETN  = 1'b1;
      RD_READY = 1'b1;

      // Single ch0 transfer
      CH0_ADRS = 32'h0000_1000; CH0_LEN = 10'd15; CH0_REQ = 1'b1;
      push(0, 32'h0000_1000, 10'd15, 0);
      serve(0, 4, lat);
      check("start_latency", 64'(lat), 64'd2);
      CH0_REQ = 1'b0;
      @(negedge ACLK);
      check("done_one_cycle", 64'({CH1_DONE, CH0_DONE}), 64'd0);

      // Simultaneous requests held for four transfers
      CH0_ADRS = 32'hA000_0000; CH0_LEN = 10'd8;
      CH1_ADRS = 32'hB000_0040; CH1_LEN = 10'd20;
      CH0_REQ = 1'b1; CH1_REQ = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (order[k] == 0) push(0, 32'hA000_0000, 10'd8, 0);
         else               push(1, 32'hB000_0040, 10'd20, 0);
      end
      for (int k = 0; k < 4; k++) serve(order[k], 2, lat);
      CH0_REQ = 1'b0; CH1_REQ = 1'b0;
      @(negedge ACLK);

      // FIFO write-enable steering during a ch1 transfer
      f0 = fifo_cnt0; f1 = fifo_cnt1;
      CH1_ADRS = 32'h0000_3000; CH1_LEN = 10'd16; CH1_REQ = 1'b1;
      push(1, 32'h0000_3000, 10'd16, 0);
      serve(1, 16, lat);
      CH1_REQ = 1'b0;
      check("fifo_we_ch1", 64'(fifo_cnt1 - f1), 64'd16);
      check("fifo_we_ch0", 64'(fifo_cnt0 - f0), 64'd0);

      // Stray FIFO write and RD_DONE while idle
      @(negedge ACLK);
      f0 = fifo_cnt0; f1 = fifo_cnt1; d0 = done_cnt;
      RD_FIFO_WE = 1'b1; RD_DONE = 1'b1;
      repeat (3) @(negedge ACLK);
      RD_FIFO_WE = 1'b0; RD_DONE = 1'b0;
      @(negedge ACLK);
      check("idle_fifo_we", 64'((fifo_cnt0 - f0) + (fifo_cnt1 - f1)), 64'd0);
      check("idle_rd_done", 64'(done_cnt - d0), 64'd0);

      // Oversized ch1 burst is rejected
      s0 = start_cnt;
      CH1_ADRS = 32'h0000_4000; CH1_LEN = 10'd300; CH1_REQ = 1'b1;
      push(1, 32'h0000_4000, 10'd300, 1);
      lat = 0;
      while (!CH1_ERR && lat < 50) begin
         @(negedge ACLK);
         lat++;
      end
      check("err_latency", 64'(lat), 64'd1);
      check("err_no_issue", 64'(start_cnt - s0), 64'd0);
      CH1_REQ = 1'b0;
      // Next request, at the largest legal length, is served normally
      CH0_ADRS = 32'h0000_2000; CH0_LEN = 10'd255; CH0_REQ = 1'b1;
      push(0, 32'h0000_2000, 10'd255, 0);
      serve(0, 1, lat);
      check("after_err_latency", 64'(lat), 64'd2);
      CH0_REQ = 1'b0;
      @(negedge ACLK);

      // Read master busy holds off the grant
      RD_READY = 1'b0;
      s0 = start_cnt;
      CH1_ADRS = 32'h0000_5000; CH1_LEN = 10'd7; CH1_REQ = 1'b1;
      push(1, 32'h0000_5000, 10'd7, 0);
      repeat (5) @(negedge ACLK);
      check("not_ready_start", 64'(start_cnt - s0), 64'd0);
      check("not_ready_grant", 64'({CH1_GRANT, CH0_GRANT}), 64'd0);
      RD_READY = 1'b1;
      serve(1, 0, lat);
      check("ready_latency", 64'(lat), 64'd1);
      CH1_REQ = 1'b0;
      @(negedge ACLK);

      // Reset while BUSY
      CH0_ADRS = 32'h0000_6000; CH0_LEN = 10'd5; CH0_REQ = 1'b1;
      push(0, 32'h0000_6000, 10'd5, 0);
      wait_start(lat);
      @(posedge ACLK); #1;
      ARESETN = 1'b0;
      CH0_REQ = 1'b0;
      d0 = done_cnt;
      @(negedge ACLK);
      @(negedge ACLK);
      check("busy_rst_outputs", all_outs(), 64'd0);
      check("busy_rst_adrs", 64'(RD_ADRS), 64'd0);
      check("busy_rst_len", 64'(RD_LEN), 64'd0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(negedge ACLK);
      check("busy_rst_no_done", 64'(done_cnt - d0), 64'd0);

      // First tie after reset
      CH0_ADRS = 32'h0000_7000; CH0_LEN = 10'd3;
      CH1_ADRS = 32'h0000_8000; CH1_LEN = 10'd4;
      CH0_REQ = 1'b1; CH1_REQ = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (order2[k] == 0) push(0, 32'h0000_7000, 10'd3, 0);
         else                push(1, 32'h0000_8000, 10'd4, 0);
      end
      for (int k = 0; k < 2; k++) serve(order2[k], 1, lat);
      CH0_REQ = 1'b0; CH1_REQ = 1'b0;
      repeat (2) @(negedge ACLK);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
